// File: rtl/core_pipe_mem.sv
// core_pipe_mem: memory-issue stage between execute (s2) and writeback (s3).
//
// Holds one instruction. A load or store issues a single doubleword-aligned
// data memory request with byte strobes and lane-positioned store data. The
// instruction is offered to writeback only after the request is granted, so
// load data is already valid while the instruction sits in writeback.
//
// Optional feature macro: CORE_LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word/double accesses issue no request and are
//               turned into a trap (s3_trap=1, s3_rd = 4 load / 6 store).
//   undefined : every untrapped load/store issues a request; strobes that
//               run past the doubleword boundary are simply dropped.
//
// LSU op encoding (s2_lsu_op[4:0]):
//   [4] load, [3] store, [2] unsigned load (passed through),
//   [1:0] size: 0 byte, 1 half, 2 word, 3 double. 5'b0 = no memory op.
// s2_csr_op[2:0], s2_cfu_op[2:0], s2_wb_op[1:0] are passed through untouched.
//
// Ports:
//   g_clk, g_reset       clock, synchronous active-high reset
//   flush                discard the held instruction
//   s2_valid / s2_ready  handshake from execute; s2_* payload
//   s3_valid / s3_ready  handshake to writeback; s3_* registered payload
//   dmem_req/addr/wen/strb/wdata  data memory request (held until dmem_gnt)
//   dmem_gnt             request accepted
module core_pipe_mem #(
  parameter int XLEN       = 64,
  parameter int MEM_ADDR_W = 64
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  flush,
  input  logic                  s2_valid,
  output logic                  s2_ready,
  input  logic [XLEN-1:0]       s2_pc,
  input  logic [XLEN-1:0]       s2_n_pc,
  input  logic [31:0]           s2_instr,
  input  logic [XLEN-1:0]       s2_addr,
  input  logic [XLEN-1:0]       s2_wdata,
  input  logic [4:0]            s2_rd,
  input  logic [4:0]            s2_lsu_op,
  input  logic [2:0]            s2_csr_op,
  input  logic [2:0]            s2_cfu_op,
  input  logic [1:0]            s2_wb_op,
  input  logic                  s2_trap,
  output logic                  s3_valid,
  input  logic                  s3_ready,
  output logic [XLEN-1:0]       s3_pc,
  output logic [XLEN-1:0]       s3_n_pc,
  output logic [31:0]           s3_instr,
  output logic [XLEN-1:0]       s3_wdata,
  output logic [4:0]            s3_rd,
  output logic [4:0]            s3_lsu_op,
  output logic [2:0]            s3_csr_op,
  output logic [2:0]            s3_cfu_op,
  output logic [1:0]            s3_wb_op,
  output logic                  s3_trap,
  output logic                  dmem_req,
  output logic [MEM_ADDR_W-1:0] dmem_addr,
  output logic                  dmem_wen,
  output logic [7:0]            dmem_strb,
  output logic [63:0]           dmem_wdata,
  input  logic                  dmem_gnt
);

  localparam int XL = XLEN - 1;

  // One-hot so dmem_req is a plain flop bit.
  localparam logic [2:0] EMPTY = 3'b001;
  localparam logic [2:0] REQ   = 3'b010;
  localparam logic [2:0] DONE  = 3'b100;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       kill;
  logic       kill_nxt;
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       issue;
  logic       take;
  logic [2:0] off;
  logic [1:0] size;

  function automatic logic [7:0] lane_strb(input logic [1:0] sz, input logic [2:0] ofs);
    logic [7:0] base;
    case (sz)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    // Bytes shifted past bit 7 cross the doubleword and are dropped.
    return base << ofs;
  endfunction

  function automatic logic [63:0] lane_wdata(input logic [63:0] d, input logic [2:0] ofs);
    return d << {ofs, 3'b000};
  endfunction

  assign off      = s2_addr[2:0];
  assign size     = s2_lsu_op[1:0];
  assign is_load  = s2_lsu_op[4];
  assign is_store = s2_lsu_op[3] && !s2_lsu_op[4];
  assign is_mem   = is_load || is_store;

`ifdef CORE_LSU_MISALIGN_TRAP_EN
  logic mis;

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] ofs);
    case (sz)
      2'd1:    return ofs[0];
      2'd2:    return |ofs[1:0];
      2'd3:    return |ofs;
      default: return 1'b0;
    endcase
  endfunction

  assign mis   = is_mem && misaligned(size, off);
  assign issue = is_mem && !s2_trap && !mis;
`else
  assign issue = is_mem && !s2_trap;
`endif

  // Flush always wins over a new offer, so s2 is never accepted while flushing.
  assign s2_ready = !flush && ((state == EMPTY) || ((state == DONE) && s3_ready));
  assign take     = s2_valid && s2_ready;
  assign s3_valid = (state == DONE) && !flush;
  assign dmem_req = state[1];

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    case (state)
      EMPTY: begin
        if (take) state_nxt = issue ? REQ : DONE;
      end
      REQ: begin
        // A request already on the bus is never withdrawn; a flush only
        // marks it so the instruction is dropped once the grant arrives.
        if (flush) kill_nxt = 1'b1;
        if (dmem_gnt) begin
          state_nxt = (kill || flush) ? EMPTY : DONE;
          kill_nxt  = 1'b0;
        end
      end
      DONE: begin
        if (flush)         state_nxt = EMPTY;
        else if (s3_ready) state_nxt = take ? (issue ? REQ : DONE) : EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // s2 -> s3 boundary: payload and memory request registers
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state      <= EMPTY;
      kill       <= 1'b0;
      s3_pc      <= '0;
      s3_n_pc    <= '0;
      s3_instr   <= '0;
      s3_wdata   <= '0;
      s3_rd      <= '0;
      s3_lsu_op  <= '0;
      s3_csr_op  <= '0;
      s3_cfu_op  <= '0;
      s3_wb_op   <= '0;
      s3_trap    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wen   <= 1'b0;
      dmem_strb  <= '0;
      dmem_wdata <= '0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (take) begin
        s3_pc     <= s2_pc;
        s3_n_pc   <= s2_n_pc;
        s3_instr  <= s2_instr;
        // Loads carry the byte address so writeback can pick the lane.
        s3_wdata  <= is_load ? s2_addr : s2_wdata;
        s3_lsu_op <= s2_lsu_op;
        s3_csr_op <= s2_csr_op;
        s3_cfu_op <= s2_cfu_op;
        s3_wb_op  <= s2_wb_op;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
        if (mis && !s2_trap) begin
          s3_trap <= 1'b1;
          s3_rd   <= is_load ? 5'd4 : 5'd6;
        end else begin
          s3_trap <= s2_trap;
          s3_rd   <= s2_rd;
        end
`else
        s3_trap <= s2_trap;
        s3_rd   <= s2_rd;
`endif
      end
      if (take && issue) begin
        dmem_addr  <= MEM_ADDR_W'({s2_addr[XL:3], 3'b000});
        dmem_wen   <= is_store;
        dmem_strb  <= lane_strb(size, off);
        dmem_wdata <= lane_wdata(64'(s2_wdata), off);
      end
    end
  end

endmodule

// File: tb/tb_core_pipe_mem.sv
// Testbench for core_pipe_mem: directed steps followed by a randomized run
// checked against a transaction-level reference model.
module tb_core_pipe_mem;

`ifdef CORE_LSU_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  localparam logic [4:0] LSU_NONE = 5'b00000;
  localparam logic [4:0] LSU_LH   = 5'b10001;
  localparam logic [4:0] LSU_LW   = 5'b10010;
  localparam logic [4:0] LSU_LD   = 5'b10011;
  localparam logic [4:0] LSU_SB   = 5'b01000;
  localparam logic [4:0] LSU_SD   = 5'b01011;

  logic        g_clk, g_reset, flush;
  logic        s2_valid, s2_ready;
  logic [63:0] s2_pc, s2_n_pc, s2_addr, s2_wdata;
  logic [31:0] s2_instr;
  logic [4:0]  s2_rd, s2_lsu_op;
  logic [2:0]  s2_csr_op, s2_cfu_op;
  logic [1:0]  s2_wb_op;
  logic        s2_trap;
  logic        s3_valid, s3_ready;
  logic [63:0] s3_pc, s3_n_pc, s3_wdata;
  logic [31:0] s3_instr;
  logic [4:0]  s3_rd, s3_lsu_op;
  logic [2:0]  s3_csr_op, s3_cfu_op;
  logic [1:0]  s3_wb_op;
  logic        s3_trap;
  logic        dmem_req, dmem_wen, dmem_gnt;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_strb;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] pc, n_pc, wdata;
    logic [31:0] instr;
    logic [4:0]  rd, lsu;
    logic [2:0]  csr, cfu;
    logic [1:0]  wb;
    logic        trap;
  } s3_exp_t;

  typedef struct {
    logic [63:0] addr, wdata;
    logic [7:0]  strb;
    logic        wen;
  } req_exp_t;

  s3_exp_t  sq[$];
  req_exp_t rq[$];

  core_pipe_mem #(.XLEN(64), .MEM_ADDR_W(64)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .s2_valid(s2_valid), .s2_ready(s2_ready),
    .s2_pc(s2_pc), .s2_n_pc(s2_n_pc), .s2_instr(s2_instr),
    .s2_addr(s2_addr), .s2_wdata(s2_wdata), .s2_rd(s2_rd),
    .s2_lsu_op(s2_lsu_op), .s2_csr_op(s2_csr_op), .s2_cfu_op(s2_cfu_op),
    .s2_wb_op(s2_wb_op), .s2_trap(s2_trap),
    .s3_valid(s3_valid), .s3_ready(s3_ready),
    .s3_pc(s3_pc), .s3_n_pc(s3_n_pc), .s3_instr(s3_instr),
    .s3_wdata(s3_wdata), .s3_rd(s3_rd), .s3_lsu_op(s3_lsu_op),
    .s3_csr_op(s3_csr_op), .s3_cfu_op(s3_cfu_op), .s3_wb_op(s3_wb_op),
    .s3_trap(s3_trap),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic nxt();
    @(posedge g_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge g_clk);
  endtask

  task automatic offer(input logic [63:0] pc, input logic [4:0] lsu, input logic [63:0] addr,
                       input logic [63:0] data, input logic [4:0] rd, input logic trap);
    s2_valid  = 1'b1;
    s2_pc     = pc;
    s2_n_pc   = pc + 64'd4;
    s2_instr  = $urandom;
    s2_addr   = addr;
    s2_wdata  = data;
    s2_rd     = rd;
    s2_lsu_op = lsu;
    s2_csr_op = 3'($urandom_range(0, 7));
    s2_cfu_op = 3'($urandom_range(0, 7));
    s2_wb_op  = 2'($urandom_range(0, 3));
    s2_trap   = trap;
  endtask

  // Reference model: what the accepted instruction must produce, from the
  // architectural rules (byte counts, modulo arithmetic).
  task automatic expect_accept();
    s3_exp_t  e;
    req_exp_t r;
    int       nbytes;
    int       ofs;
    bit       ld, st, mem, aligned;
    nbytes  = 1 << int'(s2_lsu_op[1:0]);
    ofs     = int'(s2_addr % 64'd8);
    aligned = (s2_addr % 64'(nbytes)) == 64'd0;
    ld      = s2_lsu_op[4];
    st      = s2_lsu_op[3] && !ld;
    mem     = ld || st;
    e.pc    = s2_pc;
    e.n_pc  = s2_n_pc;
    e.instr = s2_instr;
    e.lsu   = s2_lsu_op;
    e.csr   = s2_csr_op;
    e.cfu   = s2_cfu_op;
    e.wb    = s2_wb_op;
    e.wdata = ld ? s2_addr : s2_wdata;
    e.trap  = s2_trap;
    e.rd    = s2_rd;
    if (mem && !s2_trap && MIS_EN && !aligned) begin
      e.trap = 1'b1;
      e.rd   = ld ? 5'd4 : 5'd6;
    end else if (mem && !s2_trap) begin
      r.addr  = s2_addr - 64'(ofs);
      r.strb  = 8'(((1 << nbytes) - 1) << ofs);
      r.wdata = s2_wdata << (8 * ofs);
      r.wen   = st;
      rq.push_back(r);
    end
    sq.push_back(e);
  endtask

  task automatic monitor();
    if (dmem_req) begin
      check("rnd_req_expected", 64'(rq.size() > 0), 64'd1);
      check("rnd_s2_ready_in_req", 64'(s2_ready), 64'd0);
      if (rq.size() > 0) begin
        check("rnd_dmem_addr", dmem_addr, rq[0].addr);
        check("rnd_dmem_strb", 64'(dmem_strb), 64'(rq[0].strb));
        check("rnd_dmem_wen", 64'(dmem_wen), 64'(rq[0].wen));
        if (rq[0].wen) check("rnd_dmem_wdata", dmem_wdata, rq[0].wdata);
        if (dmem_gnt) void'(rq.pop_front());
      end
    end
    if (s3_valid) begin
      check("rnd_s3_before_gnt", 64'(rq.size()), 64'd0);
      if (s3_ready) begin
        check("rnd_s3_expected", 64'(sq.size() > 0), 64'd1);
        if (sq.size() > 0) begin
          check("rnd_s3_pc", s3_pc, sq[0].pc);
          check("rnd_s3_n_pc", s3_n_pc, sq[0].n_pc);
          check("rnd_s3_instr", 64'(s3_instr), 64'(sq[0].instr));
          check("rnd_s3_wdata", s3_wdata, sq[0].wdata);
          check("rnd_s3_rd", 64'(s3_rd), 64'(sq[0].rd));
          check("rnd_s3_trap", 64'(s3_trap), 64'(sq[0].trap));
          check("rnd_s3_ops", 64'({s3_lsu_op, s3_csr_op, s3_cfu_op, s3_wb_op}),
                64'({sq[0].lsu, sq[0].csr, sq[0].cfu, sq[0].wb}));
          void'(sq.pop_front());
        end
      end
    end
    if (s2_valid && s2_ready) expect_accept();
  endtask

  initial begin
    logic [63:0] pc_ctr;
    bit          accepted;
    g_reset = 1'b1; flush = 1'b0; s2_valid = 1'b0; s3_ready = 1'b0; dmem_gnt = 1'b0;
    s2_pc = '0; s2_n_pc = '0; s2_instr = '0; s2_addr = '0; s2_wdata = '0; s2_rd = '0;
    s2_lsu_op = '0; s2_csr_op = '0; s2_cfu_op = '0; s2_wb_op = '0; s2_trap = 1'b0;

    // Reset state
    nxt(); nxt(); mid();
    check("rst_s3_valid", 64'(s3_valid), 64'd0);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_s3_pc", s3_pc, 64'd0);
    check("rst_dmem_strb", 64'(dmem_strb), 64'd0);
    nxt(); g_reset = 1'b0; mid();
    check("rst_s2_ready", 64'(s2_ready), 64'd1);

    // Four back-to-back ALU ops
    s3_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nxt(); offer(64'h100 + 64'(4 * k), LSU_NONE, 64'd0, 64'h1000 + 64'(k), 5'd1, 1'b0);
      mid();
      check("add_s2_ready", 64'(s2_ready), 64'd1);
      if (k > 0) begin
        check("add_s3_valid", 64'(s3_valid), 64'd1);
        check("add_s3_pc", s3_pc, 64'h100 + 64'(4 * (k - 1)));
        check("add_no_req", 64'(dmem_req), 64'd0);
      end
    end
    nxt(); s2_valid = 1'b0; mid();
    check("add_last_valid", 64'(s3_valid), 64'd1);
    check("add_last_wdata", s3_wdata, 64'h1003);
    nxt(); mid();
    check("add_empty", 64'(s3_valid), 64'd0);

    // SB at 0x1003 with grant delayed three cycles
    nxt(); offer(64'h200, LSU_SB, 64'h1003, 64'hAB, 5'd0, 1'b0); mid();
    for (int i = 0; i < 4; i++) begin
      nxt(); s2_valid = 1'b0; dmem_gnt = (i == 3); mid();
      check("sb_req", 64'(dmem_req), 64'd1);
      check("sb_addr", dmem_addr, 64'h1000);
      check("sb_strb", 64'(dmem_strb), 64'h08);
      check("sb_wdata", dmem_wdata, 64'hAB00_0000);
      check("sb_wen", 64'(dmem_wen), 64'd1);
      check("sb_s3_valid", 64'(s3_valid), 64'd0);
      check("sb_s2_ready", 64'(s2_ready), 64'd0);
    end
    nxt(); dmem_gnt = 1'b0; mid();
    check("sb_done_valid", 64'(s3_valid), 64'd1);
    check("sb_done_req", 64'(dmem_req), 64'd0);
    check("sb_s3_wdata", s3_wdata, 64'hAB);
    nxt(); mid();
    check("sb_empty", 64'(s3_valid), 64'd0);

    // LW at 0x2004, immediate grant
    nxt(); offer(64'h300, LSU_LW, 64'h2004, 64'h5555, 5'd2, 1'b0); mid();
    nxt(); s2_valid = 1'b0; dmem_gnt = 1'b1; mid();
    check("lw_req", 64'(dmem_req), 64'd1);
    check("lw_addr", dmem_addr, 64'h2000);
    check("lw_strb", 64'(dmem_strb), 64'hF0);
    check("lw_wen", 64'(dmem_wen), 64'd0);
    nxt(); dmem_gnt = 1'b0; mid();
    check("lw_s3_valid", 64'(s3_valid), 64'd1);
    check("lw_s3_wdata", s3_wdata, 64'h2004);
    check("lw_req_off", 64'(dmem_req), 64'd0);
    nxt(); mid();

    // Misaligned LH at 0x3001 and SD at 0x3004
    nxt(); offer(64'h400, LSU_LH, 64'h3001, 64'd0, 5'd7, 1'b0); mid();
    nxt(); s2_valid = 1'b0; dmem_gnt = 1'b1; mid();
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    check("lh_no_req", 64'(dmem_req), 64'd0);
    check("lh_s3_valid", 64'(s3_valid), 64'd1);
    check("lh_trap", 64'(s3_trap), 64'd1);
    check("lh_cause", 64'(s3_rd), 64'd4);
`else
    check("lh_req", 64'(dmem_req), 64'd1);
    check("lh_addr", dmem_addr, 64'h3000);
    check("lh_strb", 64'(dmem_strb), 64'h06);
`endif
    nxt(); dmem_gnt = 1'b0; mid();
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    check("lh_gone", 64'(s3_valid), 64'd0);
`else
    check("lh_s3_valid", 64'(s3_valid), 64'd1);
    check("lh_no_trap", 64'(s3_trap), 64'd0);
    check("lh_rd", 64'(s3_rd), 64'd7);
`endif
    nxt(); mid();
    nxt(); offer(64'h500, LSU_SD, 64'h3004, 64'h1122_3344_5566_7788, 5'd9, 1'b0); mid();
    nxt(); s2_valid = 1'b0; dmem_gnt = 1'b1; mid();
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    check("sd_no_req", 64'(dmem_req), 64'd0);
    check("sd_trap", 64'(s3_trap), 64'd1);
    check("sd_cause", 64'(s3_rd), 64'd6);
`else
    check("sd_req", 64'(dmem_req), 64'd1);
    check("sd_addr", dmem_addr, 64'h3000);
    check("sd_strb", 64'(dmem_strb), 64'hF0);
    check("sd_wdata", dmem_wdata, 64'h5566_7788_0000_0000);
    check("sd_wen", 64'(dmem_wen), 64'd1);
`endif
    nxt(); dmem_gnt = 1'b0; mid();
    nxt(); mid();

    // Flush while a request is outstanding; grant two cycles later
    nxt(); offer(64'h600, LSU_LD, 64'h4000, 64'd0, 5'd5, 1'b0); mid();
    nxt(); s2_valid = 1'b0; flush = 1'b1; mid();
    check("fl_req_held", 64'(dmem_req), 64'd1);
    check("fl_s2_ready0", 64'(s2_ready), 64'd0);
    nxt(); flush = 1'b0; mid();
    check("fl_req_held2", 64'(dmem_req), 64'd1);
    check("fl_s2_ready1", 64'(s2_ready), 64'd0);
    nxt(); dmem_gnt = 1'b1; mid();
    check("fl_gnt_no_valid", 64'(s3_valid), 64'd0);
    check("fl_s2_ready2", 64'(s2_ready), 64'd0);
    nxt(); dmem_gnt = 1'b0; mid();
    check("fl_after_valid", 64'(s3_valid), 64'd0);
    check("fl_after_req", 64'(dmem_req), 64'd0);
    check("fl_after_ready", 64'(s2_ready), 64'd1);

    // Flush in DONE, then flush in EMPTY against a live offer
    s3_ready = 1'b0;
    nxt(); offer(64'h800, LSU_NONE, 64'd0, 64'h77, 5'd1, 1'b0); mid();
    nxt(); offer(64'h804, LSU_NONE, 64'd0, 64'h78, 5'd1, 1'b0); flush = 1'b1; mid();
    check("fd_valid_gated", 64'(s3_valid), 64'd0);
    check("fd_s2_ready", 64'(s2_ready), 64'd0);
    nxt(); mid();
    check("fe_valid", 64'(s3_valid), 64'd0);
    nxt(); flush = 1'b0; s2_valid = 1'b0; mid();
    check("fe_not_taken", 64'(s3_valid), 64'd0);
    check("fe_ready", 64'(s2_ready), 64'd1);

    // Reset while a request is outstanding
    nxt(); offer(64'h900, LSU_LD, 64'h5000, 64'd0, 5'd5, 1'b0); mid();
    nxt(); s2_valid = 1'b0; g_reset = 1'b1; mid();
    check("rr_req_before", 64'(dmem_req), 64'd1);
    nxt(); g_reset = 1'b0; mid();
    check("rr_req_dropped", 64'(dmem_req), 64'd0);
    check("rr_addr_clr", dmem_addr, 64'd0);

    // Writeback stalled for five cycles, then reset
    nxt(); offer(64'hA00, LSU_NONE, 64'd0, 64'hDEAD, 5'd3, 1'b0); mid();
    for (int i = 0; i < 5; i++) begin
      nxt(); offer(64'hB00, LSU_NONE, 64'd0, 64'hBEEF, 5'd4, 1'b0); mid();
      check("st_valid", 64'(s3_valid), 64'd1);
      check("st_pc", s3_pc, 64'hA00);
      check("st_wdata", s3_wdata, 64'hDEAD);
      check("st_s2_ready", 64'(s2_ready), 64'd0);
    end
    nxt(); s2_valid = 1'b0; g_reset = 1'b1; mid();
    nxt(); g_reset = 1'b0; mid();
    check("st_rst_valid", 64'(s3_valid), 64'd0);
    check("st_rst_pc", s3_pc, 64'd0);
    check("st_rst_wdata", s3_wdata, 64'd0);
    check("st_rst_rd", 64'(s3_rd), 64'd0);

    // Upstream trap passes through unchanged
    s3_ready = 1'b1;
    nxt(); offer(64'hC00, LSU_NONE, 64'd0, 64'd1, 5'd2, 1'b1); mid();
    nxt(); s2_valid = 1'b0; mid();
    check("ut_trap", 64'(s3_trap), 64'd1);
    check("ut_rd", 64'(s3_rd), 64'd2);
    nxt(); mid();

    // Randomized traffic against the reference model
    pc_ctr   = 64'h1_0000;
    accepted = 1'b0;
    for (int c = 0; c < 900; c++) begin
      nxt();
      if (accepted) s2_valid = 1'b0;
      accepted = 1'b0;
      if (!s2_valid && c < 800 && $urandom_range(0, 3) != 0) begin
        int          kind;
        logic [4:0]  lsu;
        kind = $urandom_range(0, 2);
        lsu  = (kind == 0) ? LSU_NONE :
               (kind == 1) ? {2'b10, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))} :
                             {3'b010, 2'($urandom_range(0, 3))};
        offer(pc_ctr, lsu, {$urandom, $urandom}, {$urandom, $urandom},
              5'($urandom_range(0, 31)), (kind == 0) && ($urandom_range(0, 7) == 0));
        pc_ctr = pc_ctr + 64'd4;
      end
      s3_ready = (c >= 800) || ($urandom_range(0, 3) != 0);
      dmem_gnt = (c >= 800) || ($urandom_range(0, 1) != 0);
      mid();
      if (s2_valid && s2_ready) accepted = 1'b1;
      monitor();
    end
    check("rnd_s3_drained", 64'(sq.size()), 64'd0);
    check("rnd_req_drained", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
